dcnt60: RTL

Two-digit BCD modulo-60 down counter, the decrementing counterpart of the seconds/minutes up counter. Counts 59 → 00 on an enable or a manual decrement strobe, wraps to 59, and raises a borrow to the next-higher stage when it underflows. Includes a synchronous parallel load with range checking, so a countdown-timer chain can be preset (e.g. mm:ss) and run toward zero.

---
 rtl/dcnt60.sv | 118 +++++++++++
 1 files changed

// File: rtl/dcnt60.sv
// dcnt60 -- two-digit BCD modulo-60 down counter with borrow out and
// range-checked synchronous parallel load.
//
// Counts 59 -> 00 on CEN (borrow-in from a lower stage) or DEC (manual
// strobe), then wraps to 59. Only a CEN-driven step at 00 raises BO, so a
// borrow cascades up a timer chain while a user button never does.
//
// Build option:
//   DCNT60_HOLD_AT_ZERO_EN  when defined, the counter saturates at 00
//                           instead of wrapping; BO keeps its formula, so
//                           it stays high every cycle CEN is high at 00.
//
// Ports:
//   clk         in   system clock, rising edge
//   n_rst       in   synchronous reset, active-low
//   CEN         in   count enable / borrow-in, decrements by one
//   DEC         in   manual decrement strobe, never produces BO
//   LD          in   parallel load strobe (wins over CEN/DEC)
//   LD_TENS     in   [2:0] load value, tens digit (legal 0-5)
//   LD_ONES     in   [3:0] load value, ones digit (legal 0-9)
//   tens_place  out  [2:0] tens digit, registered
//   ones_place  out  [3:0] ones digit, registered
//   BO          out  borrow out, combinational
//   ZERO        out  value is 00, combinational
//   LD_ERR      out  registered one-cycle pulse: previous LD was illegal
module dcnt60 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       CEN,
  input  logic       DEC,
  input  logic       LD,
  input  logic [2:0] LD_TENS,
  input  logic [3:0] LD_ONES,
  output logic [2:0] tens_place,
  output logic [3:0] ones_place,
  output logic       BO,
  output logic       ZERO,
  output logic       LD_ERR
);

  logic [2:0] r_tens;
  logic [3:0] r_ones;
  logic       r_ld_err;

  logic [2:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;
  logic       w_ld_err_nxt;
  logic       w_step;
  logic       w_zero;
  logic       w_ld_ok;

  // A load value is accepted only if both digits are legal BCD for mod-60.
  function automatic logic ld_legal(input logic [2:0] t, input logic [3:0] o);
    return (t <= 3'd5) && (o <= 4'd9);
  endfunction

  // CEN and DEC together still count once.
  assign w_step  = CEN | DEC;
  assign w_zero  = (r_tens == 3'd0) && (r_ones == 4'd0);
  assign w_ld_ok = ld_legal(LD_TENS, LD_ONES);

  // Next-state selection: load, then decrement, then hold.
  always_comb begin
    w_tens_nxt   = r_tens;
    w_ones_nxt   = r_ones;
    w_ld_err_nxt = 1'b0;
    if (LD) begin
      if (w_ld_ok) begin
        w_tens_nxt = LD_TENS;
        w_ones_nxt = LD_ONES;
      end else begin
        // Rejected load keeps the digits and flags the error.
        w_ld_err_nxt = 1'b1;
      end
    end else if (w_step) begin
      if (r_ones != 4'd0) begin
        w_ones_nxt = r_ones - 4'd1;
      end else if (r_tens != 3'd0) begin
        w_ones_nxt = 4'd9;
        w_tens_nxt = r_tens - 3'd1;
      end else begin
`ifdef DCNT60_HOLD_AT_ZERO_EN
        // Timer expired: stay parked at 00.
        w_ones_nxt = 4'd0;
        w_tens_nxt = 3'd0;
`else
        // Underflow wraps to 59.
        w_ones_nxt = 4'd9;
        w_tens_nxt = 3'd5;
`endif
      end
    end else begin
      w_tens_nxt = r_tens;
      w_ones_nxt = r_ones;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_tens   <= 3'd0;
      r_ones   <= 4'd0;
      r_ld_err <= 1'b0;
    end else begin
      r_tens   <= w_tens_nxt;
      r_ones   <= w_ones_nxt;
      r_ld_err <= w_ld_err_nxt;
    end
  end

  assign tens_place = r_tens;
  assign ones_place = r_ones;
  assign LD_ERR     = r_ld_err;
  assign ZERO       = w_zero;
  // Borrow only from CEN so it can feed the next stage's CEN in the same cycle.
  assign BO         = CEN & ~LD & w_zero;

endmodule
